// File: rtl/rr_mux_pkg.sv
// Shared types and helpers for the round-robin valid/ready multiplexer.
// The packet-lock FSM type is used only when RR_MUX_LOCK_EN is defined.
package rr_mux_pkg;

    localparam int N_MIN = 2;
    localparam int N_MAX = 16;
    localparam int W_MIN = 1;
    localparam int W_MAX = 64;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } lock_state_t;

    // Channel index width, never narrower than one bit.
    function automatic int ch_w_f(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr, with wrap-around.
module rr_arbiter #(
    parameter int N    = 4,
    parameter int CH_W = 2
) (
    input  logic [N-1:0]    req,
    input  logic [CH_W-1:0] ptr,
    input  logic            en,
    output logic [N-1:0]    gnt,
    output logic [CH_W-1:0] gnt_idx
);

    localparam int IW = $clog2(2 * N);

    logic [2*N-1:0] req2_s;
    logic [IW-1:0]  pos_s;
    logic           found_s;

    // Scan the doubled request vector from ptr so wrap-around needs no modulo.
    always_comb begin
        req2_s  = {req, req};
        pos_s   = '0;
        found_s = 1'b0;
        gnt_idx = '0;
        gnt     = '0;
        for (int i = 0; i < N; i++) begin
            pos_s = IW'(ptr) + IW'(i);
            if (!found_s && req2_s[pos_s]) begin
                found_s = 1'b1;
                if (pos_s >= IW'(N)) begin
                    gnt_idx = CH_W'(pos_s - IW'(N));
                end else begin
                    gnt_idx = CH_W'(pos_s);
                end
            end else begin
                found_s = found_s;
            end
        end
        if (found_s && en) begin
            gnt[gnt_idx] = 1'b1;
        end else begin
            gnt = '0;
        end
    end

endmodule

// File: rtl/rr_mux.sv
// N-channel round-robin valid/ready multiplexer with a single registered output stage.
// Define RR_MUX_LOCK_EN to hold the grant on one channel until its in_last beat.
module rr_mux
    import rr_mux_pkg::*;
#(
    parameter int  N    = 4,
    parameter int  W    = 8,
    localparam int CH_W = ch_w_f(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    in_valid,
    input  logic [N*W-1:0]  in_data,
    output logic [N-1:0]    in_ready,
    output logic            out_valid,
    output logic [W-1:0]    out_data,
    output logic [CH_W-1:0] out_ch,
    input  logic            out_ready
`ifdef RR_MUX_LOCK_EN
    ,
    input  logic [N-1:0]    in_last,
    output logic            out_last
`endif
);

    if (N < N_MIN || N > N_MAX || W < W_MIN || W > W_MAX) begin : g_param_check
        $error("rr_mux: N or W out of range");
    end

    logic [N-1:0]    gnt_s;
    logic [N-1:0]    in_ready_s;
    logic [CH_W-1:0] arb_idx_s;
    logic [CH_W-1:0] sel_idx_s;
    logic [CH_W-1:0] ptr_nxt_s;
    logic            load_en_s;
    logic            arb_en_s;
    logic            accept_s;

    logic            out_valid_r;
    logic [W-1:0]    out_data_r;
    logic [CH_W-1:0] out_ch_r;
    logic [CH_W-1:0] ptr_r;

    // Reset also forces ready low so nothing is granted while the block is held.
    assign load_en_s = !out_valid_r || out_ready;
    assign arb_en_s  = load_en_s && rst_n;

    rr_arbiter #(
        .N    (N),
        .CH_W (CH_W)
    ) u_arbiter (
        .req     (in_valid),
        .ptr     (ptr_r),
        .en      (arb_en_s),
        .gnt     (gnt_s),
        .gnt_idx (arb_idx_s)
    );

`ifdef RR_MUX_LOCK_EN
    lock_state_t     state_r;
    logic [CH_W-1:0] lock_ch_r;
    logic            out_last_r;

    // While locked, the grant stays on the packet owner even if it is idle.
    always_comb begin
        in_ready_s = '0;
        if (state_r == LOCKED) begin
            sel_idx_s             = lock_ch_r;
            in_ready_s[lock_ch_r] = arb_en_s;
        end else begin
            sel_idx_s  = arb_idx_s;
            in_ready_s = gnt_s;
        end
    end

    // Packet-lock FSM and registered end-of-packet marker.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            lock_ch_r  <= '0;
            out_last_r <= 1'b0;
        end else if (accept_s) begin
            out_last_r <= in_last[sel_idx_s];
            case (state_r)
                IDLE: begin
                    if (!in_last[sel_idx_s]) begin
                        state_r   <= LOCKED;
                        lock_ch_r <= sel_idx_s;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                LOCKED: begin
                    if (in_last[sel_idx_s]) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= LOCKED;
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

    assign out_last = out_last_r;
`else
    // Per-word arbitration: the arbiter grant drives ready directly.
    always_comb begin
        sel_idx_s  = arb_idx_s;
        in_ready_s = gnt_s;
    end
`endif

    // Accept decode and next pointer; in lock mode the selected channel is lock_ch.
    always_comb begin
        accept_s = |(in_valid & in_ready_s);
        if (sel_idx_s == CH_W'(N - 1)) begin
            ptr_nxt_s = '0;
        end else begin
            ptr_nxt_s = sel_idx_s + CH_W'(1);
        end
    end

    // Output register and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_ch_r    <= '0;
            ptr_r       <= '0;
        end else if (accept_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= in_data[sel_idx_s*W +: W];
            out_ch_r    <= sel_idx_s;
            ptr_r       <= ptr_nxt_s;
        end else if (load_en_s && out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_ch    = out_ch_r;

endmodule

// File: tb/tb_rr_mux.sv
// Directed, table-driven bench for rr_mux (N=4, W=8); lock cases run when RR_MUX_LOCK_EN is defined.
module tb_rr_mux;

    logic        clk;
    logic        rst_n;
    logic [3:0]  in_valid;
    logic [31:0] in_data;
    logic [3:0]  in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  out_ch;
    logic        out_ready;
`ifdef RR_MUX_LOCK_EN
    logic [3:0]  in_last;
    logic        out_last;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [3:0]  vld;
        logic [31:0] data;
        logic [3:0]  last;
        logic        rdy;
        logic [3:0]  exp_ir;
        logic        exp_ov;
        logic [7:0]  exp_od;
        logic [1:0]  exp_ch;
        logic        exp_ol;
    } vec_t;

    vec_t vecs[$];

    rr_mux #(.N(4), .W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_ready (out_ready)
`ifdef RR_MUX_LOCK_EN
        ,
        .in_last   (in_last),
        .out_last  (out_last)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [3:0] vld, input logic [31:0] data,
                                input logic [3:0] last, input logic rdy,
                                input logic [3:0] ir, input logic ov,
                                input logic [7:0] od, input logic [1:0] ch,
                                input logic ol);
        vec_t v;
        v.vld = vld; v.data = data; v.last = last; v.rdy = rdy;
        v.exp_ir = ir; v.exp_ov = ov; v.exp_od = od; v.exp_ch = ch; v.exp_ol = ol;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Entered and left at posedge+1; ready is checked before the edge, outputs after it.
    task automatic apply(input vec_t v, input string tag);
        in_valid  = v.vld;
        in_data   = v.data;
        out_ready = v.rdy;
`ifdef RR_MUX_LOCK_EN
        in_last   = v.last;
`endif
        #1;
        chk({tag, " in_ready"}, 64'(in_ready), 64'(v.exp_ir));
        @(posedge clk);
        #1;
        chk({tag, " out_valid"}, 64'(out_valid), 64'(v.exp_ov));
        chk({tag, " out_data"}, 64'(out_data), 64'(v.exp_od));
        chk({tag, " out_ch"}, 64'(out_ch), 64'(v.exp_ch));
`ifdef RR_MUX_LOCK_EN
        chk({tag, " out_last"}, 64'(out_last), 64'(v.exp_ol));
`endif
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        for (int c = 0; c < 3; c++) begin
            in_valid  = 4'($urandom);
            in_data   = 32'($urandom);
            out_ready = 1'($urandom);
`ifdef RR_MUX_LOCK_EN
            in_last   = 4'($urandom);
`endif
            #1;
            chk($sformatf("%s c%0d in_ready", tag, c), 64'(in_ready), 64'd0);
            chk($sformatf("%s c%0d out_valid", tag, c), 64'(out_valid), 64'd0);
            chk($sformatf("%s c%0d out_data", tag, c), 64'(out_data), 64'd0);
            chk($sformatf("%s c%0d out_ch", tag, c), 64'(out_ch), 64'd0);
`ifdef RR_MUX_LOCK_EN
            chk($sformatf("%s c%0d out_last", tag, c), 64'(out_last), 64'd0);
`endif
            @(posedge clk);
            #1;
        end
        in_valid  = 4'd0;
        out_ready = 1'b0;
        rst_n     = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b1;
        in_valid  = 4'd0;
        in_data   = 32'd0;
        out_ready = 1'b0;
`ifdef RR_MUX_LOCK_EN
        in_last   = 4'hF;
`endif
        @(posedge clk);
        #1;
        do_reset("reset");

        // All channels valid: strict rotation starting at ptr 0.
        vecs.push_back(mk(4'hF, 32'hA3A2A1A0, 4'hF, 1'b1, 4'b0001, 1'b1, 8'hA0, 2'd0, 1'b1));
        vecs.push_back(mk(4'hF, 32'hA3A2A1A0, 4'hF, 1'b1, 4'b0010, 1'b1, 8'hA1, 2'd1, 1'b1));
        vecs.push_back(mk(4'hF, 32'hA3A2A1A0, 4'hF, 1'b1, 4'b0100, 1'b1, 8'hA2, 2'd2, 1'b1));
        vecs.push_back(mk(4'hF, 32'hA3A2A1A0, 4'hF, 1'b1, 4'b1000, 1'b1, 8'hA3, 2'd3, 1'b1));
        vecs.push_back(mk(4'hF, 32'hA3A2A1A0, 4'hF, 1'b1, 4'b0001, 1'b1, 8'hA0, 2'd0, 1'b1));
        vecs.push_back(mk(4'hF, 32'hA3A2A1A0, 4'hF, 1'b1, 4'b0010, 1'b1, 8'hA1, 2'd1, 1'b1));
        vecs.push_back(mk(4'hF, 32'hA3A2A1A0, 4'hF, 1'b1, 4'b0100, 1'b1, 8'hA2, 2'd2, 1'b1));
        // ptr = 3, only ch2 valid: search wraps to ch2, ptr returns to 3.
        vecs.push_back(mk(4'b0100, 32'h005C0000, 4'hF, 1'b1, 4'b0100, 1'b1, 8'h5C, 2'd2, 1'b1));
        // Backpressure for five cycles: hold 0x5C, no ready.
        for (int k = 0; k < 5; k++)
            vecs.push_back(mk(4'b0100, 32'h00770000, 4'hF, 1'b0, 4'b0000, 1'b1, 8'h5C, 2'd2, 1'b1));
        // Release: next word accepted in the same cycle.
        vecs.push_back(mk(4'b0100, 32'h00770000, 4'hF, 1'b1, 4'b0100, 1'b1, 8'h77, 2'd2, 1'b1));
        // Drain, then an empty output with the sink stalled.
        vecs.push_back(mk(4'b0000, 32'h00770000, 4'hF, 1'b1, 4'b0000, 1'b0, 8'h77, 2'd2, 1'b1));
        vecs.push_back(mk(4'b0000, 32'h00770000, 4'hF, 1'b0, 4'b0000, 1'b0, 8'h77, 2'd2, 1'b1));
        // ch1 and ch3 valid, ptr = 3: empty register loads even with out_ready low.
        vecs.push_back(mk(4'b1010, 32'h11223344, 4'hF, 1'b0, 4'b1000, 1'b1, 8'h11, 2'd3, 1'b1));
        vecs.push_back(mk(4'b1010, 32'h11223344, 4'hF, 1'b0, 4'b0000, 1'b1, 8'h11, 2'd3, 1'b1));
        vecs.push_back(mk(4'b1010, 32'h11223344, 4'hF, 1'b1, 4'b0010, 1'b1, 8'h33, 2'd1, 1'b1));
        vecs.push_back(mk(4'b1010, 32'h11223344, 4'hF, 1'b1, 4'b1000, 1'b1, 8'h11, 2'd3, 1'b1));

        foreach (vecs[i]) apply(vecs[i], $sformatf("v%0d", i));

`ifdef RR_MUX_LOCK_EN
        do_reset("lock reset");
        apply(mk(4'b0001, 32'h00000010, 4'b0001, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0, 1'b1), "L0 ch0 single");
        apply(mk(4'b0011, 32'h0000B110, 4'b0001, 1'b1, 4'b0010, 1'b1, 8'hB1, 2'd1, 1'b0), "L1 beat1");
        apply(mk(4'b0001, 32'h0000B110, 4'b0001, 1'b1, 4'b0010, 1'b0, 8'hB1, 2'd1, 1'b0), "L2 owner idle");
        apply(mk(4'b0011, 32'h0000B210, 4'b0001, 1'b1, 4'b0010, 1'b1, 8'hB2, 2'd1, 1'b0), "L3 beat2");
        apply(mk(4'b0011, 32'h0000B310, 4'b0011, 1'b1, 4'b0010, 1'b1, 8'hB3, 2'd1, 1'b1), "L4 beat3");
        apply(mk(4'b0011, 32'h0000B410, 4'b0011, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0, 1'b1), "L5 ptr2 to ch0");
        apply(mk(4'b0011, 32'h0000C110, 4'b0001, 1'b1, 4'b0010, 1'b1, 8'hC1, 2'd1, 1'b0), "L6 beat1");
        apply(mk(4'b0011, 32'h0000C210, 4'b0001, 1'b1, 4'b0010, 1'b1, 8'hC2, 2'd1, 1'b0), "L7 beat2");
        do_reset("mid-packet reset");
        apply(mk(4'b0011, 32'h0000C310, 4'b0011, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0, 1'b1), "L8 after reset");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
